// File: rtl/firebird7_in_gate2_tessent_ijtag_shift_engine.sv
// IJTAG network initiator for the gate2 instrument segment.
// Takes host scan commands, sequences sel/ce/se/ue/si into the local
// SIB/TDR chain, collects ijtag_so and returns it as a response.
// Optional build macro: FIREBIRD7_IJTAG_ENGINE_SETTLE_EN adds a 2-cycle
// SETTLE state (sel held, enables low) after UPDATE.
module firebird7_in_gate2_tessent_ijtag_shift_engine #(
  parameter int MAX_BITS = 64,
  parameter int LEN_W    = 7
) (
  input  logic                ijtag_tck,
  input  logic                ijtag_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                cmd_capture,
  input  logic                cmd_update,
  input  logic [MAX_BITS-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                rsp_err,
  output logic                ijtag_sel,
  output logic                ijtag_ce,
  output logic                ijtag_se,
  output logic                ijtag_ue,
  output logic                ijtag_si,
  input  logic                ijtag_so
);

  localparam int              IDX_W   = $clog2(MAX_BITS);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CAPTURE, ST_SHIFT, ST_UPDATE, ST_SETTLE, ST_RESP
  } state_t;

  // Saturate a requested scan length to the data-vector width.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, cnt_q, eff_len;
  logic                upd_q, err_q;
  logic [MAX_BITS-1:0] tx_q, tx_d, rx_q;
  logic                accept, shift_last;
  logic                sel_d, ce_d, se_d, ue_d, si_d, rsp_valid_d, cmd_ready_d;
`ifdef FIREBIRD7_IJTAG_ENGINE_SETTLE_EN
  logic                settle_q;
`endif

  assign eff_len    = sat_len(cmd_len);
  assign accept     = (state_q == ST_IDLE) && cmd_valid && cmd_ready;
  assign shift_last = (cnt_q == len_q - LEN_W'(1));

  // State register.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next-state: walk CAPTURE -> SHIFT -> UPDATE, skipping disabled phases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_capture)          state_d = ST_CAPTURE;
          else if (eff_len != '0)   state_d = ST_SHIFT;
          else if (cmd_update)      state_d = ST_UPDATE;
          else                      state_d = ST_RESP;
        end
      end
      ST_CAPTURE: begin
        if (len_q != '0)            state_d = ST_SHIFT;
        else if (upd_q)             state_d = ST_UPDATE;
        else                        state_d = ST_RESP;
      end
      ST_SHIFT: begin
        if (shift_last)             state_d = upd_q ? ST_UPDATE : ST_RESP;
      end
`ifdef FIREBIRD7_IJTAG_ENGINE_SETTLE_EN
      ST_UPDATE:                    state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_q)               state_d = ST_RESP;
      end
`else
      ST_UPDATE:                    state_d = ST_RESP;
`endif
      ST_RESP: begin
        if (rsp_ready)              state_d = ST_IDLE;
      end
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Next shift-out vector; si is taken from it so si is registered too.
  always_comb begin
    tx_d = tx_q;
    if (accept)                     tx_d = cmd_data;
    else if (state_q == ST_SHIFT)   tx_d = tx_q >> 1;
  end

  // Output decode from the next state, registered below.
  always_comb begin
    sel_d       = 1'b0;
    ce_d        = 1'b0;
    se_d        = 1'b0;
    ue_d        = 1'b0;
    si_d        = 1'b0;
    rsp_valid_d = 1'b0;
    cmd_ready_d = 1'b0;
    case (state_d)
      ST_IDLE:    cmd_ready_d = 1'b1;
      ST_CAPTURE: begin sel_d = 1'b1; ce_d = 1'b1; end
      ST_SHIFT:   begin sel_d = 1'b1; se_d = 1'b1; si_d = tx_d[0]; end
      ST_UPDATE:  begin sel_d = 1'b1; ue_d = 1'b1; end
      ST_SETTLE:  sel_d = 1'b1;
      ST_RESP:    rsp_valid_d = 1'b1;
      default:    cmd_ready_d = 1'b0;
    endcase
  end

  // Registered network and handshake outputs.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      ijtag_sel <= 1'b0;
      ijtag_ce  <= 1'b0;
      ijtag_se  <= 1'b0;
      ijtag_ue  <= 1'b0;
      ijtag_si  <= 1'b0;
      rsp_valid <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      ijtag_sel <= sel_d;
      ijtag_ce  <= ce_d;
      ijtag_se  <= se_d;
      ijtag_ue  <= ue_d;
      ijtag_si  <= si_d;
      rsp_valid <= rsp_valid_d;
      cmd_ready <= cmd_ready_d;
    end
  end

  // Command latch, shift counter and receive vector.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      len_q <= '0;
      cnt_q <= '0;
      upd_q <= 1'b0;
      err_q <= 1'b0;
      rx_q  <= '0;
    end else if (accept) begin
      len_q <= eff_len;
      cnt_q <= '0;
      upd_q <= cmd_update;
      err_q <= (cmd_len > MAX_LEN);
      rx_q  <= '0;
    end else if (state_q == ST_SHIFT) begin
      rx_q[cnt_q[IDX_W-1:0]] <= ijtag_so;
      cnt_q <= cnt_q + LEN_W'(1);
    end
  end

  // Shift-out data needs no reset: si is only driven from it inside SHIFT.
  always_ff @(posedge ijtag_tck) begin
    tx_q <= tx_d;
  end

`ifdef FIREBIRD7_IJTAG_ENGINE_SETTLE_EN
  // Marks the second SETTLE cycle.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) settle_q <= 1'b0;
    else              settle_q <= (state_q == ST_SETTLE) && !settle_q;
  end
`endif

  assign rsp_data = rx_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_firebird7_in_gate2_tessent_ijtag_shift_engine.sv
// Self-checking bench for the gate2 IJTAG shift engine.
module tb_firebird7_in_gate2_tessent_ijtag_shift_engine;

  logic        ijtag_tck = 1'b0;
  logic        ijtag_reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_len = '0;
  logic        cmd_capture = 1'b0;
  logic        cmd_update = 1'b0;
  logic [63:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic        ijtag_so;

  int tests = 0;
  int fails = 0;
  int mode  = 0;              // 0: 1-flop loopback, 1: SIB + 1-bit TDR

  // Responder state
  logic lb_q, sib_sr, tdr_sr, sib_open;
  // Transaction-level SIB model state
  bit   m_sib = 0, m_tdr = 0, m_open = 0;

  // Expected per-cycle vector {sel,ce,se,ue,si,rsp_valid,cmd_ready}
  logic [6:0] exp_q[$];

  always #5 ijtag_tck = ~ijtag_tck;

  firebird7_in_gate2_tessent_ijtag_shift_engine #(.MAX_BITS(64), .LEN_W(7)) dut (
    .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_capture(cmd_capture), .cmd_update(cmd_update), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .ijtag_sel(ijtag_sel), .ijtag_ce(ijtag_ce),
    .ijtag_se(ijtag_se), .ijtag_ue(ijtag_ue), .ijtag_si(ijtag_si),
    .ijtag_so(ijtag_so)
  );

  always @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) lb_q <= 1'b0;
    else              lb_q <= ijtag_si;
  end

  always @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sib_sr <= 1'b0; tdr_sr <= 1'b0; sib_open <= 1'b0;
    end else if (mode == 1 && ijtag_sel && ijtag_se) begin
      sib_sr <= ijtag_si;
      if (sib_open) tdr_sr <= sib_sr;
    end else if (mode == 1 && ijtag_sel && ijtag_ue) begin
      sib_open <= sib_sr;
    end
  end

  assign ijtag_so = (mode == 0) ? lb_q : (sib_open ? tdr_sr : sib_sr);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, rsp_valid, cmd_ready};
  endfunction

  // Per-cycle compare against the scheduled waveform plus enable exclusivity.
  always @(negedge ijtag_tck) begin
    logic [6:0] e;
    bit ok;
    ok = ((int'(ijtag_ce) + int'(ijtag_se) + int'(ijtag_ue)) <= 1) &&
         (ijtag_sel || !(ijtag_ce || ijtag_se || ijtag_ue));
    chk("enable_exclusive", {63'b0, ok}, 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("cycle_outputs", {57'b0, outs()}, {57'b0, e});
    end
  end

  // Issue one command, schedule its waveform, then check the response.
  task automatic do_cmd(input logic [6:0] len, input bit cap, input bit upd,
                        input logic [63:0] d, input int hold,
                        input bit lit_en, input logic [63:0] lit);
    int eff, lat;
    bit err, prev;
    logic [63:0] exp, held;
    eff = (len > 7'd64) ? 64 : int'(len);
    err = (len > 7'd64);
    exp = '0;
    if (mode == 0) begin
      prev = 1'b0;
      for (int k = 0; k < eff; k++) begin exp[k] = prev; prev = d[k]; end
    end else begin
      for (int k = 0; k < eff; k++) begin
        exp[k] = m_open ? m_tdr : m_sib;
        if (m_open) m_tdr = m_sib;
        m_sib = d[k];
      end
      if (upd) m_open = m_sib;
    end
    lat = int'(cap) + eff + int'(upd) + 1;
`ifdef FIREBIRD7_IJTAG_ENGINE_SETTLE_EN
    if (upd) lat += 2;
`endif
    @(negedge ijtag_tck);
    cmd_len = len; cmd_capture = cap; cmd_update = upd; cmd_data = d;
    cmd_valid = 1'b1;
    #1 chk("cmd_ready_idle", {63'b0, cmd_ready}, 64'd1);
    @(posedge ijtag_tck);
    if (cap) exp_q.push_back(7'b1100000);
    for (int k = 0; k < eff; k++) exp_q.push_back({4'b1010, d[k], 2'b00});
    if (upd) exp_q.push_back(7'b1001000);
`ifdef FIREBIRD7_IJTAG_ENGINE_SETTLE_EN
    if (upd) begin exp_q.push_back(7'b1000000); exp_q.push_back(7'b1000000); end
`endif
    exp_q.push_back(7'b0000010);
    #1 cmd_valid = 1'b0;
    repeat (lat) @(negedge ijtag_tck);
    #1;
    chk("rsp_valid_latency", {63'b0, rsp_valid}, 64'd1);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_err", {63'b0, rsp_err}, {63'b0, err});
    if (lit_en) chk("rsp_data_literal", rsp_data, lit);
    held = rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge ijtag_tck);
      cmd_valid = 1'b1;       // offered while busy: must not be taken
      #1;
      chk("hold_rsp_valid", {63'b0, rsp_valid}, 64'd1);
      chk("hold_rsp_data", rsp_data, held);
      chk("hold_cmd_ready", {63'b0, cmd_ready}, 64'd0);
    end
    @(negedge ijtag_tck);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge ijtag_tck);
    #1 rsp_ready = 1'b0;
    @(negedge ijtag_tck);
    chk("post_rsp_idle", {57'b0, outs()}, 64'b0000001);
  endtask

  initial begin
    // Reset held for 3 cycles
    ijtag_reset = 1'b0;
    repeat (3) @(posedge ijtag_tck);
    @(negedge ijtag_tck);
    ijtag_reset = 1'b1;
    #1;
    chk("reset_outputs", {57'b0, outs()}, 64'b0000001);
    chk("reset_rsp_data", rsp_data, 64'd0);
    chk("reset_rsp_err", {63'b0, rsp_err}, 64'd0);

    // Loopback through a 1-flop register
    mode = 0;
    do_cmd(7'd8, 1'b1, 1'b1, 64'hA5, 0, 1'b1, 64'h4A);
    do_cmd(7'd5, 1'b0, 1'b0, 64'h1B, 0, 1'b1, 64'h16);

    // SIB open / access TDR / close
    mode = 1;
    do_cmd(7'd1, 1'b0, 1'b1, 64'h1, 0, 1'b1, 64'h0);
    do_cmd(7'd2, 1'b0, 1'b1, 64'h2, 0, 1'b1, 64'h2);
    do_cmd(7'd1, 1'b0, 1'b1, 64'h0, 0, 1'b1, 64'h0);
    do_cmd(7'd2, 1'b0, 1'b0, 64'h3, 0, 1'b1, 64'h2);

    // Clamp, then error clears on next accept
    mode = 0;
    do_cmd(7'd100, 1'b0, 1'b1, 64'hDEADBEEF_01234567, 0, 1'b1, 64'hBD5B7DDE_02468ACE);
    do_cmd(7'd4, 1'b1, 1'b0, 64'h9, 0, 1'b1, 64'h2);

    // Zero length with back-pressure
    do_cmd(7'd0, 1'b0, 1'b1, 64'hFFFF, 5, 1'b1, 64'h0);

    // Mid-shift reset
    begin
      int rv_seen;
      @(negedge ijtag_tck);
      cmd_len = 7'd16; cmd_capture = 1'b0; cmd_update = 1'b1;
      cmd_data = 64'hF0F0; cmd_valid = 1'b1;
      @(posedge ijtag_tck);
      #1 cmd_valid = 1'b0;
      repeat (3) @(negedge ijtag_tck);
      #1 chk("mid_shift_active", {63'b0, ijtag_se}, 64'd1);
      #1 ijtag_reset = 1'b0;
      #1;
      chk("async_reset_outputs", {57'b0, outs()}, 64'b0000001);
      chk("async_reset_rsp_data", rsp_data, 64'd0);
      repeat (2) @(negedge ijtag_tck);
      ijtag_reset = 1'b1;
      rv_seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge ijtag_tck);
        if (rsp_valid) rv_seen++;
      end
      chk("no_rsp_after_reset", 64'(rv_seen), 64'd0);
      do_cmd(7'd4, 1'b0, 1'b1, 64'h6, 0, 1'b1, 64'hC);
    end

    repeat (2) @(negedge ijtag_tck);
    chk("schedule_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/firebird7_in_gate2_tessent_ijtag_shift_engine.md
Name: firebird7_in_gate2_tessent_ijtag_shift_engine

Overview:
- IJTAG network initiator (driver side) for the gate2 instrument segment.
- Accepts host scan commands (length, shift-in data, capture/update flags) and sequences ijtag_sel/ce/se/ue/si into a chain of SIBs and TDRs.
- Collects ijtag_so returned from the network and hands it back as a response.
- Sits between the gate2 test-controller host logic and the first SIB of the local IJTAG network.

Parameters:
- MAX_BITS, 64, maximum scan length per command; width of the data vectors.
- LEN_W, 7, width of cmd_len; must satisfy 2^LEN_W > MAX_BITS.

Ports:
- ijtag_tck  input  1  engine clock; also the network TCK; all engine state on posedge.
- ijtag_reset  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  engine idle and able to accept.
- cmd_len  input  LEN_W  number of shift cycles; 0 means no shift.
- cmd_capture  input  1  issue one capture cycle before shifting.
- cmd_update  input  1  issue one update cycle after shifting.
- cmd_data  input  MAX_BITS  shift-in data, bit 0 shifted first.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  host accepts the response.
- rsp_data  output  MAX_BITS  captured ijtag_so bits, bit 0 = first sampled.
- rsp_err  output  1  cmd_len exceeded MAX_BITS (length was clamped).
- ijtag_sel  output  1  network select.
- ijtag_ce  output  1  capture enable.
- ijtag_se  output  1  shift enable.
- ijtag_ue  output  1  update enable.
- ijtag_si  output  1  scan data into the network.
- ijtag_so  input  1  scan data from the network; stable at posedge because responders retime it on the low phase.

Behaviour:
- Single clock ijtag_tck. Reset is asynchronous, active-low, on ijtag_reset.
- Reset values: all ijtag_* outputs 0, rsp_valid 0, rsp_err 0, rsp_data 0, cmd_ready 1.
- All outputs are registered on posedge ijtag_tck.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, RESP.
- IDLE: cmd_ready=1, sel=0.
  - On cmd_valid & cmd_ready, latch len/flags/data, clear the rx vector, and go to the first enabled state in the order CAPTURE, SHIFT (if len>0), UPDATE.
  - If no state is enabled, go directly to RESP.
- CAPTURE: exactly 1 cycle with sel=1, ce=1, se=0, ue=0.
- SHIFT: exactly len cycles with sel=1, se=1.
  - si = tx[0].
  - On each posedge, rx[cnt] <= ijtag_so, tx shifts right, cnt increments.
  - Leave SHIFT when cnt == len-1 at that edge.
- UPDATE: exactly 1 cycle with sel=1, ue=1, se=0, ce=0, si=0.
- RESP:
  - sel=0 and all enables 0.
  - rsp_valid=1, with rsp_data and rsp_err held stable until rsp_valid & rsp_ready, then return to IDLE.
  - cmd_ready=0 throughout RESP.
- Latency: acceptance edge to rsp_valid = (cmd_capture) + len + (cmd_update) + 1 cycles.
- ce, se and ue are mutually exclusive, and none is asserted while sel=0.
- Length clamp: cmd_len > MAX_BITS is treated as MAX_BITS and sets rsp_err=1 for that response. rsp_err clears on the next accept.
- rsp_data bits at index >= effective len read 0.
- sel stays high continuously from CAPTURE through UPDATE, with no gap between states.
- cmd_valid arriving while busy is not accepted: cmd_ready=0, and the host must hold the command.
- Reset asserted mid-operation: outputs drop to reset values immediately (asynchronous). Any partial response is discarded and no rsp_valid is produced.

Optional Feature:
- Macro: FIREBIRD7_IJTAG_ENGINE_SETTLE_EN.
- Defined:
  - After UPDATE, a SETTLE state holds sel=1 with all enables 0 for 2 cycles before RESP. This lets downstream SIB to_sel outputs, which follow update by two falling edges, settle.
  - Latency increases by 2 for commands with cmd_update=1 only.
- Undefined: no SETTLE state; UPDATE goes straight to RESP.

Test Plan:
- Reset: hold ijtag_reset=0 for 3 cycles, then release -> all ijtag_* = 0, cmd_ready=1, rsp_valid=0.
- Loopback: tie so to si through a 1-flop register; cmd len=8, data=0xA5, capture=1, update=1 -> ce for 1 cycle, se for 8, ue for 1; rsp_valid at cycle 11; rsp_data=0x4A (bit 0 = register reset value 0).
- SIB open: single SIB responder; cmd len=1, data=1, update=1 -> then len=2 sees the SIB and the 1-bit TDR in path; len=1, data=0, update=1 closes it; rsp_data of the second command bit 0 reflects the TDR.
- Clamp: cmd_len=100, MAX_BITS=64 -> exactly 64 se cycles, rsp_err=1; next command with len=4 -> rsp_err=0.
- Zero length: len=0, capture=0, update=1 -> one ue cycle, no se; rsp_data=0; back-pressure with rsp_ready=0 for 5 cycles holds rsp_valid and rsp_data stable, and cmd_ready stays 0.
- Mid-shift reset: assert reset during shift cycle 3 of len=16 -> outputs go to 0 asynchronously, no rsp_valid; after release, a new command with len=4 completes normally.
